pc_sequencer: RTL and testbench

Parametrised program-counter sequencer, the next generation of the instruction-fetch counter. Drives the instruction-memory address from controller strobes. Besides the basic increment it supports absolute jump, signed relative branch, stall, and call/return through an internal LIFO return-address stack. Sits between the control state machine and instruction memory, and reports stack fault and wrap status back to the controller.

---
 rtl/pc_seq_if.sv | 35 +++
 rtl/pc_sequencer.sv | 80 ++++++++
 tb/tb_pc_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// Controller <-> pc_sequencer strobe and status bundle.
// Master drives the strobes, slave returns the registered address and status.
interface pc_seq_if #(
  parameter int ADDR_W      = 7,
  parameter int OFF_W       = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic              stall;
  logic              up;
  logic              load;
  logic              branch;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] address;
  logic [DW-1:0]     depth;
  logic              wrap;
  logic              overflow;
  logic              underflow;

  modport master (
    output stall, up, load, branch, call, ret,
    output target, offset,
    input  address, depth, wrap, overflow, underflow
  );

  modport slave (
    input  stall, up, load, branch, call, ret,
    input  target, offset,
    output address, depth, wrap, overflow, underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, jump, relative branch, stall,
// and call/return through a small LIFO return-address stack.
module pc_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int OFF_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input logic     clk,
  input logic     clear,
  pc_seq_if.slave bus
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [DW-1:0]     dep_q;
  logic              wrap_q;
  logic              ovf_q;
  logic              unf_q;

  logic [ADDR_W-1:0] sext;
  logic [ADDR_W-1:0] addr_inc;
  logic [IW-1:0]     push_idx;
  logic [IW-1:0]     top_idx;
  logic              full;
  logic              empty;

  assign sext     = ADDR_W'($signed(bus.offset));
  assign addr_inc = addr_q + 1'b1;
  assign push_idx = dep_q[IW-1:0];
  assign top_idx  = IW'(dep_q - 1'b1);
  assign full     = (dep_q == DW'(STACK_DEPTH));
  assign empty    = (dep_q == '0);

  // One action per cycle, highest-priority strobe wins.
  always_ff @(posedge clk) begin
    wrap_q <= 1'b0;
    if (clear) begin
      addr_q <= '0;
      dep_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      priority case (1'b1)
        bus.stall: ;
        bus.ret: begin
          if (empty) begin
            unf_q <= 1'b1;
          end else begin
            addr_q <= stack_q[top_idx];
            dep_q  <= dep_q - 1'b1;
          end
        end
        bus.call: begin
          if (full) begin
            ovf_q <= 1'b1;
          end else begin
            stack_q[push_idx] <= addr_inc;
            dep_q             <= dep_q + 1'b1;
            addr_q            <= bus.target;
          end
        end
        bus.load:   addr_q <= bus.target;
        bus.branch: addr_q <= addr_q + sext;
        bus.up: begin
          addr_q <= addr_inc;
          wrap_q <= (addr_q == '1);
        end
        default: ;
      endcase
    end
  end

  assign bus.address   = addr_q;
  assign bus.depth     = dep_q;
  assign bus.wrap      = wrap_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table,
// counting sequence, and random stimulus against a queue-based model.
module tb_pc_sequencer;
  localparam int ADDR_W = 7;
  localparam int OFF_W  = 4;
  localparam int SD     = 4;
  localparam int AMAX   = 2 ** ADDR_W;

  typedef struct {
    bit        clr, stl, up, ld, br, cl, rt;
    bit [6:0]  tgt;
    bit [3:0]  off;
  } in_t;

  typedef struct {
    in_t i;
    int  ea, ed;
    bit  ew, eo, eu;
  } vec_t;

  logic clk = 1'b0;
  logic clear = 1'b0;

  pc_seq_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(SD)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(SD)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int m_addr = 0;
  int m_q[$];
  bit m_wrap, m_ovf, m_unf;

  function automatic void chk(string n, int a, int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endfunction

  function automatic void model_step(input in_t v);
    int off;
    m_wrap = 1'b0;
    if (v.clr) begin
      m_addr = 0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (v.stl) begin
    end else if (v.rt) begin
      if (m_q.size() > 0) m_addr = m_q.pop_back();
      else m_unf = 1'b1;
    end else if (v.cl) begin
      if (m_q.size() < SD) begin
        m_q.push_back((m_addr + 1) % AMAX);
        m_addr = int'(v.tgt);
      end else m_ovf = 1'b1;
    end else if (v.ld) begin
      m_addr = int'(v.tgt);
    end else if (v.br) begin
      off = int'(v.off);
      if (off >= 2 ** (OFF_W - 1)) off -= 2 ** OFF_W;
      m_addr = ((m_addr + off) % AMAX + AMAX) % AMAX;
    end else if (v.up) begin
      if (m_addr == AMAX - 1) m_wrap = 1'b1;
      m_addr = (m_addr + 1) % AMAX;
    end
  endfunction

  task automatic apply(input in_t v);
    @(negedge clk);
    clear      = v.clr;
    bus.stall  = v.stl;
    bus.up     = v.up;
    bus.load   = v.ld;
    bus.branch = v.br;
    bus.call   = v.cl;
    bus.ret    = v.rt;
    bus.target = v.tgt;
    bus.offset = v.off;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_addr"}, int'(bus.address), m_addr);
    chk({tag, "_depth"}, int'(bus.depth), m_q.size());
    chk({tag, "_wrap"}, int'(bus.wrap), int'(m_wrap));
    chk({tag, "_ovf"}, int'(bus.overflow), int'(m_ovf));
    chk({tag, "_unf"}, int'(bus.underflow), int'(m_unf));
  endtask

  function automatic in_t mi(bit clr, bit stl, bit up, bit ld, bit br,
                             bit cl, bit rt, int tgt, int off);
    in_t v;
    v.clr = clr; v.stl = stl; v.up = up; v.ld = ld;
    v.br = br; v.cl = cl; v.rt = rt;
    v.tgt = 7'(tgt);
    v.off = 4'(off);
    return v;
  endfunction

  function automatic vec_t mv(in_t i, int ea, int ed, bit ew, bit eo, bit eu);
    vec_t r;
    r.i = i; r.ea = ea; r.ed = ed;
    r.ew = ew; r.eo = eo; r.eu = eu;
    return r;
  endfunction

  vec_t vt[$];

  initial begin
    in_t v;
    string tag;
    bus.stall = 0; bus.up = 0; bus.load = 0; bus.branch = 0;
    bus.call = 0; bus.ret = 0; bus.target = '0; bus.offset = '0;

    //            clr stl up ld br cl rt tgt off      addr dep w o u
    vt.push_back(mv(mi(1,0,0,0,0,0,0, 0, 0),   0, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,1,0,0,0, 10, 0),  10, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,1,0,0,0, 40, 0),  40, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,1,0,0, 0, 13),  37, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,1,0,0, 0, 7),   44, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,1,0,0,0, 2, 0),   2, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,1,0,0, 0, 13),  127, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,1,0,0,0, 5, 0),   5, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 20, 0),  20, 1, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 60, 0),  60, 2, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   21, 1, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   6, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 10, 0),  10, 1, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 11, 0),  11, 2, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 12, 0),  12, 3, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 13, 0),  13, 4, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 99, 0),  13, 4, 0,1,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   13, 3, 0,1,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   12, 2, 0,1,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   11, 1, 0,1,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   7, 0, 0,1,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   7, 0, 0,1,1));
    vt.push_back(mv(mi(0,0,1,0,0,0,0, 0, 0),   8, 0, 0,1,1));
    vt.push_back(mv(mi(1,0,0,0,0,0,0, 0, 0),   0, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,1,0,0,0, 8, 0),   8, 0, 0,0,0));
    vt.push_back(mv(mi(0,1,1,1,1,1,1, 50, 3),  8, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,1,1,1,1,1, 50, 3),  8, 0, 0,0,1));
    vt.push_back(mv(mi(0,0,1,1,1,1,0, 50, 3),  50, 1, 0,0,1));
    vt.push_back(mv(mi(1,0,0,0,0,0,0, 0, 0),   0, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 20, 0),  20, 1, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,1,0, 29, 0),  29, 2, 0,0,0));
    vt.push_back(mv(mi(0,0,0,1,0,0,0, 30, 0),  30, 2, 0,0,0));
    vt.push_back(mv(mi(1,0,0,0,0,0,1, 0, 0),   0, 0, 0,0,0));
    vt.push_back(mv(mi(0,0,0,0,0,0,1, 0, 0),   0, 0, 0,0,1));

    foreach (vt[k]) begin
      apply(vt[k].i);
      tag = $sformatf("vec%0d", k);
      chk({tag, "_addr"}, int'(bus.address), vt[k].ea);
      chk({tag, "_depth"}, int'(bus.depth), vt[k].ed);
      chk({tag, "_wrap"}, int'(bus.wrap), int'(vt[k].ew));
      chk({tag, "_ovf"}, int'(bus.overflow), int'(vt[k].eo));
      chk({tag, "_unf"}, int'(bus.underflow), int'(vt[k].eu));
    end

    // Reset then count through the wrap point.
    apply(mi(1,0,0,0,0,0,0, 0, 0));
    chk("cnt_reset_addr", int'(bus.address), 0);
    for (int i = 0; i < 130; i++) begin
      apply(mi(0,0,1,0,0,0,0, 0, 0));
      chk($sformatf("cnt%0d_addr", i), int'(bus.address), (i + 1) % 128);
      chk($sformatf("cnt%0d_wrap", i), int'(bus.wrap), (i == 127) ? 1 : 0);
    end
    apply(mi(0,1,0,0,0,0,0, 0, 0));
    chk("stall_after_count_wrap", int'(bus.wrap), 0);
    chk("stall_after_count_addr", int'(bus.address), 2);

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      v.clr = ($urandom_range(63) == 0);
      v.stl = ($urandom_range(7) == 0);
      v.up  = 1'($urandom_range(1));
      v.ld  = ($urandom_range(6) == 0);
      v.br  = ($urandom_range(4) == 0);
      v.cl  = ($urandom_range(3) == 0);
      v.rt  = ($urandom_range(4) == 0);
      v.tgt = ($urandom_range(7) == 0) ? 7'd127 : 7'($urandom);
      v.off = 4'($urandom);
      apply(v);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
